// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle unsigned/signed multiply, divide and remainder for the ONC-16
// datapath. One radix-2 step per clock (shift-add multiply, restoring
// shift-subtract divide); results carry the ALU's four-bit flag format.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only while busy=0
//   op     in   000 MULU, 001 MULS, 010 DIVU, 011 DIVS, 100 REMU, 101 REMS,
//               110/111 reserved
//   a      in   multiplicand / dividend
//   b      in   multiplier / divisor
//   y      out  low product word, quotient or remainder
//   y_hi   out  high product word (MUL), zero for DIV/REM
//   flags  out  [0]=Z [1]=N [2]=C [3]=V
//   busy   out  operation in progress
//   done   out  one-cycle pulse, results valid from this cycle
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] y_hi,
    output logic [3:0]        flags,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_m;       // multiplicand or divisor magnitude
    logic [2*DATA_W-1:0] r_acc;     // {hi, lo}: product, or {remainder, quotient}
    logic                r_neg_q;   // operand signs differ (product/quotient)
    logic                r_neg_r;   // dividend negative (remainder)
    logic                r_ovf;
    logic                r_bzero;
    logic [DATA_W-1:0]   r_y;
    logic [DATA_W-1:0]   r_y_hi;
    logic [3:0]          r_flags;
    logic                r_busy;
    logic                r_done;

    logic                w_signed;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_add;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_trial;
    logic [2*DATA_W-1:0] w_step;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_y;
    logic [DATA_W-1:0]   w_y_hi;
    logic [3:0]          w_flags;
    logic                w_c;
    logic                w_v;

    // Operand conditioning at the start edge.
    always_comb begin
        w_signed = (op == 3'b001) || (op == 3'b011) || (op == 3'b101);
        w_mag_a  = (w_signed && a[DATA_W-1]) ? -a : a;
        w_mag_b  = (w_signed && b[DATA_W-1]) ? -b : b;
    end

    // One iteration step. Multiply shifts the accumulator right, adding the
    // multiplicand into the high half when the current multiplier bit is set.
    // Divide shifts {rem, quotient} left and keeps the trial subtraction when
    // it does not borrow; the quotient bit enters at the bottom.
    always_comb begin
        w_add   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_m} : '0);
        w_shift = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
        w_trial = w_shift - {1'b0, r_m};
        if (r_op[2:1] == 2'b00) begin
            w_step = {w_add, r_acc[DATA_W-1:1]};
        end else if (!w_trial[DATA_W]) begin
            w_step = {w_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
        end else begin
            w_step = {w_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
        end
    end

    // Sign fix-up and flag evaluation for the FIX edge.
    always_comb begin
        w_prod = r_neg_q ? -r_acc : r_acc;
        w_quot = r_bzero ? '1  : (r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0]);
        w_rem  = r_bzero ? r_a : (r_neg_r ? -r_acc[2*DATA_W-1:DATA_W]
                                          : r_acc[2*DATA_W-1:DATA_W]);
        w_y    = '0;
        w_y_hi = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (r_op[2:1])
            2'b00: begin
                w_y    = w_prod[DATA_W-1:0];
                w_y_hi = w_prod[2*DATA_W-1:DATA_W];
                w_v    = r_op[0] ? (w_y_hi != {DATA_W{w_y[DATA_W-1]}})
                                 : (w_y_hi != '0);
            end
            2'b01: begin
                w_y = w_quot;
                w_c = r_bzero;
                w_v = r_ovf;
            end
            2'b10: begin
                w_y = w_rem;
                w_c = r_bzero;
                w_v = r_ovf;
            end
            default: ;
        endcase
        w_flags = {w_v, w_c, w_y[DATA_W-1], (w_y == '0)};
        if (r_op[2:1] == 2'b11) begin
            w_flags = 4'b0001;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_ovf   <= 1'b0;
            r_bzero <= 1'b0;
            r_y     <= '0;
            r_y_hi  <= '0;
            r_flags <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_neg_q <= w_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                        r_neg_r <= w_signed & a[DATA_W-1];
                        r_ovf   <= w_signed & (a == MOST_NEG) & (b == '1);
                        r_bzero <= (b == '0);
                        if (op[2:1] == 2'b00) begin
                            r_m   <= w_mag_a;
                            r_acc <= {{DATA_W{1'b0}}, w_mag_b};
                        end else begin
                            r_m   <= w_mag_b;
                            r_acc <= {{DATA_W{1'b0}}, w_mag_a};
                        end
                        r_cnt   <= CW'(DATA_W);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_y     <= w_y;
                    r_y_hi  <= w_y_hi;
                    r_flags <= w_flags;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign y     = r_y;
    assign y_hi  = r_y_hi;
    assign flags = r_flags;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Randomised and directed stimulus for mul_div_unit (DATA_W=16), checked
// against an arithmetic reference model. One monitor process checks busy,
// done and results every cycle against a queue of expected transactions.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic [3:0]   flags;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         ce;
        logic [2:0] op;
        logic [W-1:0] y;
        logic [W-1:0] yh;
        logic [3:0] f;
    } exp_t;

    exp_t q[$];

    mul_div_unit #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op_i),
        .a     (a_i),
        .b     (b_i),
        .y     (y),
        .y_hi  (y_hi),
        .flags (flags),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model straight from the arithmetic definitions.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] ry, output logic [W-1:0] ryh,
                                  output logic [3:0] rf);
        int     sa;
        int     sb;
        longint p;
        logic [31:0] up;
        logic   c;
        logic   v;
        sa = $signed(a);
        sb = $signed(b);
        ry = '0;
        ryh = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                up  = {16'b0, a} * {16'b0, b};
                ry  = up[15:0];
                ryh = up[31:16];
                v   = (ryh != 0);
            end
            3'd1: begin
                p   = longint'(sa) * longint'(sb);
                up  = p[31:0];
                ry  = up[15:0];
                ryh = up[31:16];
                v   = (p < -32768) || (p > 32767);
            end
            3'd2: begin
                if (b == 0) begin ry = 16'hFFFF; c = 1'b1; end
                else ry = a / b;
            end
            3'd3: begin
                if (b == 0) begin ry = 16'hFFFF; c = 1'b1; end
                else if (a == 16'h8000 && b == 16'hFFFF) begin ry = 16'h8000; v = 1'b1; end
                else ry = 16'(sa / sb);
            end
            3'd4: begin
                if (b == 0) begin ry = a; c = 1'b1; end
                else ry = a % b;
            end
            3'd5: begin
                if (b == 0) begin ry = a; c = 1'b1; end
                else if (a == 16'h8000 && b == 16'hFFFF) begin ry = 16'h0000; v = 1'b1; end
                else ry = 16'(sa % sb);
            end
            default: ;
        endcase
        rf = {v, c, ry[15], (ry == 0)};
        if (op[2:1] == 2'b11) rf = 4'b0001;
    endfunction

    // Monitor: every cycle busy/done follow the oldest outstanding request;
    // on done the results must equal the model's.
    always @(negedge clk) begin
        int d;
        if (!rst) begin
            chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
            if (q.size() > 0) begin
                d = cyc - q[0].ce;
                chk("busy", {31'b0, busy}, {31'b0, (d < LAT)});
                chk("done", {31'b0, done}, {31'b0, (d == LAT)});
                if (done) begin
                    chk($sformatf("y op%0d", q[0].op), {16'b0, y}, {16'b0, q[0].y});
                    chk($sformatf("y_hi op%0d", q[0].op), {16'b0, y_hi}, {16'b0, q[0].yh});
                    chk($sformatf("flags op%0d", q[0].op), {28'b0, flags}, {28'b0, q[0].f});
                    void'(q.pop_front());
                end else if (d >= LAT) begin
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_busy", {31'b0, busy}, 32'd0);
                chk("idle_done", {31'b0, done}, 32'd0);
            end
        end
    end

    // Issue one operation (caller is at a negedge); optionally disturb the
    // inputs and pulse start while busy; wait (bounded) for done.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit perturb);
        exp_t e;
        bit   seen;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        model(op, a, b, e.y, e.yh, e.f);
        e.op  = op;
        start = 1'b1;
        op_i  = op;
        a_i   = a;
        b_i   = b;
        @(posedge clk);
        #1;
        e.ce  = cyc;
        q.push_back(e);
        start = 1'b0;
        if (perturb) begin
            repeat ($urandom_range(1, 10)) @(negedge clk);
            a_i   = 16'($urandom);
            b_i   = 16'($urandom);
            op_i  = 3'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
    endtask

    // Directed vectors with hand-computed results: op, a, b, y, y_hi, flags.
    localparam int NV = 13;
    logic [2:0]  v_op [NV] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd3, 3'd5, 3'd2, 3'd4, 3'd5, 3'd6};
    logic [15:0] v_a  [NV] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'hEEEE, 16'hEEEE, 16'hFFF9, 16'hFFF9,
                               16'h8000, 16'h8000, 16'h1234, 16'h1234, 16'h8001, 16'h5555};
    logic [15:0] v_b  [NV] = '{16'hFFFF, 16'h0002, 16'h0002, 16'h000F, 16'h000F, 16'h0002, 16'h0002,
                               16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h1111};
    logic [15:0] v_y  [NV] = '{16'h0001, 16'hFFFE, 16'hFFFE, 16'h0FED, 16'h000B, 16'hFFFD, 16'hFFFF,
                               16'h8000, 16'h0000, 16'hFFFF, 16'h1234, 16'h8001, 16'h0000};
    logic [15:0] v_yh [NV] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [3:0]  v_f  [NV] = '{4'b1000, 4'b0010, 4'b1010, 4'b0000, 4'b0000, 4'b0010, 4'b0010,
                               4'b1010, 4'b1001, 4'b0110, 4'b0100, 4'b0110, 4'b0001};

    initial begin
        logic [W-1:0] my;
        logic [W-1:0] myh;
        logic [3:0]   mf;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        exp_t         e;

        rst   = 1'b0;
        start = 1'b0;
        op_i  = '0;
        a_i   = '0;
        b_i   = '0;
        #1 rst = 1'b1;

        // Pin the model to the hand-computed vectors.
        for (int i = 0; i < NV; i++) begin
            model(v_op[i], v_a[i], v_b[i], my, myh, mf);
            chk($sformatf("model_y[%0d]", i), {16'b0, my}, {16'b0, v_y[i]});
            chk($sformatf("model_yh[%0d]", i), {16'b0, myh}, {16'b0, v_yh[i]});
            chk($sformatf("model_f[%0d]", i), {28'b0, mf}, {28'b0, v_f[i]});
        end

        repeat (2) @(negedge clk);
        chk("rst_y", {16'b0, y}, 32'd0);
        chk("rst_y_hi", {16'b0, y_hi}, 32'd0);
        chk("rst_flags", {28'b0, flags}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back-to-back in each done cycle.
        for (int i = 0; i < NV; i++) do_op(v_op[i], v_a[i], v_b[i], (i % 3) == 1);

        // Reset mid-RUN: outputs clear at once and no done follows.
        @(negedge clk);
        start = 1'b1;
        op_i  = 3'd0;
        a_i   = 16'hFFFF;
        b_i   = 16'hFFFF;
        model(3'd0, 16'hFFFF, 16'hFFFF, e.y, e.yh, e.f);
        e.op  = 3'd0;
        @(posedge clk);
        #1;
        e.ce  = cyc;
        q.push_back(e);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        q.delete();
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_y", {16'b0, y}, 32'd0);
        chk("midrst_y_hi", {16'b0, y_hi}, 32'd0);
        chk("midrst_flags", {28'b0, flags}, 32'd0);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);

        // Fresh start after reset, then randomised traffic with boundary bias.
        do_op(3'd3, 16'hFFF9, 16'h0002, 1'b0);
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 16'h0000;
                1: rb = 16'hFFFF;
                2: begin ra = 16'h8000; rb = 16'hFFFF; end
                3: ra = 16'h8000;
                4: rb = 16'($urandom_range(1, 3));
                default: ;
            endcase
            do_op(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
